// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the ring-oscillator TDC: pulses start, captures ring/counter,
// averages 2^N_AVG_LOG2 samples and streams the sum out as bytes over valid/ready.
module tdc_meas_ctrl #(
    parameter int unsigned N_DELAY    = 64,
    parameter int unsigned N_CTR      = 16,
    parameter int unsigned N_AVG_LOG2 = 2,
    parameter int unsigned SETTLE     = 4,
    parameter int unsigned GAP        = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          i_go,
    input  logic                                          i_abort,
    output logic                                          o_tdc_start,
    input  logic [N_DELAY-1:0]                            i_result_ring,
    input  logic [N_CTR-1:0]                              i_result_ctr,
    output logic                                          o_busy,
    output logic                                          o_done,
    output logic [N_CTR+$clog2(N_DELAY)+N_AVG_LOG2-1:0]   o_meas,
    output logic [7:0]                                    o_byte,
    output logic                                          o_byte_valid,
    input  logic                                          i_byte_ready
);

    localparam int unsigned FW      = $clog2(N_DELAY);
    localparam int unsigned SW      = N_CTR + FW;
    localparam int unsigned W       = SW + N_AVG_LOG2;
    localparam int unsigned NB      = (W + 7) / 8;
    localparam int unsigned PW      = NB * 8;
    localparam int unsigned NS      = 1 << N_AVG_LOG2;
    localparam int unsigned CNT_MAX = (SETTLE > GAP) ? SETTLE : GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned AW      = (N_AVG_LOG2 > 0) ? N_AVG_LOG2 : 1;
    localparam int unsigned BW      = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CAPT,
        S_GAP,
        S_SEND,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [AW-1:0]        r_samp;
    logic [BW-1:0]        r_bidx;
    logic [N_DELAY-1:0]   r_ring;
    logic [N_CTR-1:0]     r_ctr;
    logic [W-1:0]         r_acc;
    logic [W-1:0]         r_meas;
    logic [7:0]           r_byte;
    logic                 r_start;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_valid;

    logic [FW-1:0]        w_fine;
    logic                 w_found;
    logic [SW-1:0]        w_sample;
    logic [W-1:0]         w_acc_sum;
    logic [W-1:0]         w_acc_fin;
    logic [PW-1:0]        w_meas_pad;
    logic [7:0]           w_next_byte;

    // Thermometer length from bit 0; bits past the first zero are bubbles and ignored
    always_comb begin
        w_fine  = FW'(N_DELAY - 1);
        w_found = 1'b0;
        for (int i = 0; i < int'(N_DELAY); i++) begin
            if (!w_found && !r_ring[i]) begin
                w_fine  = FW'(i);
                w_found = 1'b1;
            end
        end
    end

    assign w_sample    = {r_ctr, w_fine};
    assign w_acc_sum   = r_acc + W'(w_sample);
    assign w_acc_fin   = (r_cnt == '0) ? w_acc_sum : r_acc;
    assign w_meas_pad  = PW'(r_meas);
    assign w_next_byte = 8'(w_meas_pad >> (8 * (32'(r_bidx) + 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_samp  <= '0;
            r_bidx  <= '0;
            r_ring  <= '0;
            r_ctr   <= '0;
            r_acc   <= '0;
            r_meas  <= '0;
            r_byte  <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort && r_state != S_IDLE) begin
                r_state <= S_IDLE;
                r_start <= 1'b0;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_go) begin
                            r_state <= S_ARM;
                            r_start <= 1'b1;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_samp  <= '0;
                            r_acc   <= '0;
                        end
                    end
                    S_ARM: begin
                        if (r_cnt == CW'(SETTLE - 1)) begin
                            r_state <= S_CAPT;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_CAPT: begin
                        r_ring  <= i_result_ring;
                        r_ctr   <= i_result_ctr;
                        r_start <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_GAP;
                    end
                    S_GAP: begin
                        if (r_cnt == '0) begin
                            r_acc <= w_acc_sum;
                        end
                        if (r_cnt == CW'(GAP - 1)) begin
                            if (r_samp == AW'(NS - 1)) begin
                                r_state <= S_SEND;
                                r_meas  <= w_acc_fin;
                                r_byte  <= w_acc_fin[7:0];
                                r_valid <= 1'b1;
                                r_bidx  <= '0;
                            end else begin
                                r_samp  <= r_samp + AW'(1);
                                r_state <= S_ARM;
                                r_start <= 1'b1;
                                r_cnt   <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    // r_valid is high throughout SEND, so ready alone marks a transfer
                    S_SEND: begin
                        if (i_byte_ready) begin
                            if (r_bidx == BW'(NB - 1)) begin
                                r_valid <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_bidx <= r_bidx + BW'(1);
                                r_byte <= w_next_byte;
                            end
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_start <= 1'b0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_tdc_start  = r_start;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_meas       = r_meas;
    assign o_byte       = r_byte;
    assign o_byte_valid = r_valid;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Bench for tdc_meas_ctrl: a timeline model (cycle offsets within a burst, plain sums)
// is compared every cycle, plus directed bursts with hand-computed results.
module tb_tdc_meas_ctrl;

    localparam int P  = 4 + 1 + 2;
    localparam int NS = 4;
    localparam int NB = 3;
    localparam int W  = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_go = 1'b0;
    logic        i_abort = 1'b0;
    logic        o_tdc_start;
    logic [63:0] i_result_ring = '0;
    logic [15:0] i_result_ctr = '0;
    logic        o_busy;
    logic        o_done;
    logic [W-1:0] o_meas;
    logic [7:0]  o_byte;
    logic        o_byte_valid;
    logic        i_byte_ready = 1'b1;

    tdc_meas_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_go         (i_go),
        .i_abort      (i_abort),
        .o_tdc_start  (o_tdc_start),
        .i_result_ring(i_result_ring),
        .i_result_ctr (i_result_ctr),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_meas       (o_meas),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .i_byte_ready (i_byte_ready)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    function automatic longint exp_sample(input logic [63:0] ring, input logic [15:0] ctr);
        int fine = 0;
        while (fine < 64 && ring[fine]) fine++;
        if (fine > 63) fine = 63;
        return longint'(ctr) * 64 + longint'(fine);
    endfunction

    // Model: phase 0 idle, 1 measuring (offset m_k), 2 sending byte m_idx, 3 done pulse
    int          m_phase = 0;
    int          m_k = 0;
    int          m_idx = 0;
    longint      m_sum = 0;
    logic        exp_start = 0, exp_busy = 0, exp_done = 0, exp_valid = 0;
    logic [W-1:0] exp_meas = '0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_phase  = 0;
            exp_meas = '0;
        end else begin
            case (m_phase)
                0: if (i_go) begin m_phase = 1; m_k = 0; m_sum = 0; end
                1: if (i_abort) m_phase = 0;
                   else begin
                       if (m_k % P == 4) m_sum += exp_sample(i_result_ring, i_result_ctr);
                       m_k++;
                       if (m_k == NS * P) begin
                           m_phase  = 2;
                           m_idx    = 0;
                           exp_meas = W'(m_sum);
                       end
                   end
                2: if (i_abort) m_phase = 0;
                   else if (i_byte_ready) begin
                       m_idx++;
                       if (m_idx == NB) m_phase = 3;
                   end
                default: m_phase = 0;
            endcase
        end
        exp_start = (m_phase == 1) && (m_k % P <= 4);
        exp_busy  = (m_phase != 0);
        exp_done  = (m_phase == 3);
        exp_valid = (m_phase == 2);
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("start", 32'(o_tdc_start), 32'(exp_start));
            chk("busy", 32'(o_busy), 32'(exp_busy));
            chk("done", 32'(o_done), 32'(exp_done));
            chk("valid", 32'(o_byte_valid), 32'(exp_valid));
            chk("meas", 32'(o_meas), 32'(exp_meas));
            if (exp_valid) chk("byte", 32'(o_byte), 32'(8'(exp_meas >> (8 * m_idx))));
        end
    end

    // Transfer / activity monitor
    logic [7:0] bytes_q[$];
    int         runs_q[$];
    int         busy_cnt = 0, done_cnt = 0, run = 0;

    initial forever begin
        @(posedge clk);
        if (!rst) begin
            if (o_byte_valid && i_byte_ready) bytes_q.push_back(o_byte);
            if (o_busy) busy_cnt++;
            if (o_done) done_cnt++;
            if (o_tdc_start) run++;
            else if (run != 0) begin runs_q.push_back(run); run = 0; end
        end
    end

    task automatic clear_mon();
        bytes_q.delete();
        runs_q.delete();
        busy_cnt = 0;
        done_cnt = 0;
        run      = 0;
    endtask

    task automatic start_burst(input logic [63:0] ring, input logic [15:0] ctr);
        @(negedge clk);
        clear_mon();
        i_result_ring = ring;
        i_result_ctr  = ctr;
        i_go = 1'b1;
        @(negedge clk);
        i_go = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!o_done && n < 300) begin @(negedge clk); n++; end
        chk("done_seen", 32'(o_done), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!o_byte_valid && n < 300) begin @(negedge clk); n++; end
        chk("valid_seen", 32'(o_byte_valid), 32'd1);
    endtask

    task automatic chk_bytes(input string name, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2);
        chk({name, "_nbytes"}, 32'(bytes_q.size()), 32'd3);
        if (bytes_q.size() == 3) begin
            chk({name, "_b0"}, 32'(bytes_q[0]), 32'(b0));
            chk({name, "_b1"}, 32'(bytes_q[1]), 32'(b1));
            chk({name, "_b2"}, 32'(bytes_q[2]), 32'(b2));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(o_tdc_start), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_meas", 32'(o_meas), 0);
        chk("rst_byte", 32'(o_byte), 0);
        chk("rst_valid", 32'(o_byte_valid), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic burst: 4 x (3*64+8) = 800
        start_burst(64'hFF, 16'd3);
        wait_done();
        chk("basic_model_meas", 32'(exp_meas), 32'd800);
        chk("basic_meas", 32'(o_meas), 32'h000320);
        chk_bytes("basic", 8'h20, 8'h03, 8'h00);
        chk("basic_burst_len", 32'(busy_cnt + 1), 32'd33);
        chk("basic_done_cnt", 32'(done_cnt), 32'd1);
        chk("basic_start_runs", 32'(runs_q.size()), 32'd4);
        foreach (runs_q[i]) chk("basic_start_run_len", 32'(runs_q[i]), 32'd5);

        // Bubble suppression: fine = 4
        start_burst(64'hF0F, 16'd0);
        wait_done();
        chk("bubble_meas", 32'(o_meas), 32'd16);
        chk_bytes("bubble", 8'h10, 8'h00, 8'h00);

        // Saturation: 4 x 4194303
        start_burst('1, 16'hFFFF);
        wait_done();
        chk("sat_model_meas", 32'(exp_meas), 32'hFFFFFC);
        chk("sat_meas", 32'(o_meas), 32'hFFFFFC);
        chk_bytes("sat", 8'hFC, 8'hFF, 8'hFF);

        // Backpressure on byte 1
        start_burst(64'hFF, 16'd3);
        wait_valid();
        @(negedge clk);
        i_byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_byte_hold", 32'(o_byte), 32'h03);
            chk("bp_valid_hold", 32'(o_byte_valid), 32'd1);
        end
        i_byte_ready = 1'b1;
        wait_done();
        chk_bytes("bp", 8'h20, 8'h03, 8'h00);

        // Abort in the 3rd ARM phase; o_meas keeps 800
        start_burst(64'h0, 16'd1);
        repeat (2 * P + 1) @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort_start", 32'(o_tdc_start), 0);
        chk("abort_busy", 32'(o_busy), 0);
        chk("abort_done", 32'(o_done), 0);
        chk("abort_meas", 32'(o_meas), 32'd800);
        repeat (10) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 0);
        chk("abort_no_bytes", 32'(bytes_q.size()), 0);

        // Clean burst after abort: 4 x (2*64+3) = 524
        start_burst(64'h7, 16'd2);
        wait_done();
        chk("post_abort_meas", 32'(o_meas), 32'h20C);
        chk_bytes("post_abort", 8'h0C, 8'h02, 8'h00);

        // i_go during SEND is not queued
        start_burst(64'hFF, 16'd3);
        wait_valid();
        i_go = 1'b1;
        @(negedge clk);
        i_go = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("go_in_send_idle", 32'(o_busy), 0);
        chk_bytes("go_in_send", 8'h20, 8'h03, 8'h00);

        // rst during the first GAP cycle
        start_burst(64'hFF, 16'd3);
        begin
            int n = 0;
            while ((o_tdc_start || !o_busy) && n < 50) begin @(negedge clk); n++; end
        end
        chk("rst_gap_reached", 32'(o_busy && !o_tdc_start), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstgap_start", 32'(o_tdc_start), 0);
        chk("rstgap_busy", 32'(o_busy), 0);
        chk("rstgap_done", 32'(o_done), 0);
        chk("rstgap_meas", 32'(o_meas), 0);
        chk("rstgap_byte", 32'(o_byte), 0);
        chk("rstgap_valid", 32'(o_byte_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        repeat (60) @(negedge clk);
        chk("rstgap_no_bytes", 32'(bytes_q.size()), 0);
        chk("rstgap_idle", 32'(o_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
